counter_sched: RTL and testbench
================================

# counter_sched

Sequencing controller for the team's loadable up-counter (`counter`: synchronous clear > load > enable priority, increments modulo 2^WIDTH, registered output). It drives the counter's control inputs and watches its output. Each run loads a start value, counts to a programmed end value, then stops or reloads in one-shot or periodic mode. Host side provides start/stop/pause control, a done pulse and a period count.

## Interface
- `WIDTH`, 5, counter data width; must match the attached counter instance.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  begin a run; accepted only in IDLE.
- `stop`  in  1  abort a run; clears the counter.
- `pause`  in  1  freeze counting while high.
- `periodic`  in  1  1 = reload and repeat on end match; 0 = one-shot. Sampled with `start`.
- `start_val`  in  WIDTH  first count value; sampled with `start`.
- `end_val`  in  WIDTH  terminal count value; sampled with `start`.
- `ctr_rst`  out  1  to counter `rst`.
- `ctr_load`  out  1  to counter `load`.
- `ctr_enab`  out  1  to counter `enab`.
- `ctr_cnt_in`  out  WIDTH  to counter `cnt_in`.
- `ctr_cnt_out`  in  WIDTH  from counter `cnt_out`.
- `busy`  out  1  high in LOAD, RUN and HOLD.
- `done`  out  1  registered one-cycle pulse per completed period.
- `wraps`  out  8  completed periods since the last accepted start; saturates at 8'hFF.

## Operation
- States: CLEAR, IDLE, LOAD, RUN, HOLD.
- Reset value of the state is CLEAR. Reset values: `done`=0, `wraps`=0, shadow start/end/mode registers = 0.
- During reset: `ctr_rst`=1, `ctr_load`=0, `ctr_enab`=0, `ctr_cnt_in`=0, `busy`=0.
- CLEAR: `ctr_rst`=1 for one cycle, then IDLE.
- IDLE: all ctr controls 0.
  - On `start`=1: latch `start_val`, `end_val`, `periodic` into shadows, clear `wraps`, go to LOAD.
- LOAD: `ctr_load`=1 and `ctr_cnt_in`=shadow start; go to RUN.
- RUN: terminal = (`ctr_cnt_out` == shadow end). `ctr_enab` = !terminal.
  - On terminal: `wraps`+1 (saturating) and `done`=1 on the next cycle. Then go to LOAD if periodic, else IDLE.
  - Counter holds the end value after a one-shot run.
- RUN with `pause`=1 and not terminal: go to HOLD. The increment on that sampling edge still occurs.
- HOLD: `ctr_enab`=0. Go to RUN when `pause`=0.
- `stop`=1 in LOAD/RUN/HOLD: go to CLEAR (counter zeroed). `done` and `wraps` are not updated.
- Priority in RUN: stop > terminal > pause.
- `start` is ignored outside IDLE. `stop` is ignored in IDLE and CLEAR.
- Arithmetic: the counter wraps 2^WIDTH-1 → 0 naturally.
  - Increments per period = (end − start) mod 2^WIDTH.
  - start == end gives zero increments, and terminal is true in the first RUN cycle.
- `ctr_*` outputs decode from state, shadow registers and `ctr_cnt_out` only. There is no combinational path from `start`, `stop` or `pause`.
- Async reset mid-run returns to CLEAR immediately. `busy`, `done` and `wraps` drop to 0.

## Timing
- Cycle numbering: `start` sampled at edge 0. Then LOAD in cycle 1, RUN from cycle 2 with `ctr_cnt_out`=start.
- One-shot with no pause: `done` high in cycle 3 + D, where D = (end − start) mod 2^WIDTH. `busy` falls in the same cycle.
- Periodic: period = D + 2 cycles (1 LOAD + D+1 RUN). Consecutive `done` pulses are D + 2 cycles apart.
- Each HOLD cycle delays `done` by exactly one cycle.
- `stop`: `ctr_rst`=1 in the following cycle, and `ctr_cnt_out`=0 one cycle after that. `start` is accepted from the next IDLE cycle.

## Test plan
- Reset: hold `rst`=0 → `ctr_rst`=1, `busy`=0, `done`=0, `wraps`=0. After release, `ctr_rst`=1 for one cycle, then IDLE; the counter reads 5'h00.
- One-shot, start 5'h03, end 5'h06: counter reads 3,4,5,6; `done` in cycle 6 after `start`; counter holds 5'h06; `wraps`=1.
- Wrap, one-shot, start 5'h1E, end 5'h01: counter reads 1E,1F,00,01; `done` in cycle 6.
- Periodic, start 5'h03, end 5'h06: `done` every 5 cycles; `wraps` reads 1,2,3. Then `stop` → `ctr_rst` pulse, counter 5'h00, `busy`=0, `wraps` stays 3.
- Pause for 4 cycles, asserted while the counter reads 5'h04 (run 5'h03→5'h06): counter holds 5'h05 while paused; `done` arrives 4 cycles later than nominal.
- Edge cases:
  - start == end == 5'h0A: `done` in cycle 3.
  - `start` pulsed while busy: ignored, and the shadow values are unchanged.
  - `rst`=0 asserted in RUN: immediate CLEAR outputs.

Source files
------------

// File: rtl/counter_sched.sv
// Sequencing controller for the loadable up-counter: load start, count to end, one-shot or periodic.
// ctr_* outputs are decoded from state, shadows and ctr_cnt_out; done/wraps are registered.
module counter_sched #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  output logic             ctr_rst,
  output logic             ctr_load,
  output logic             ctr_enab,
  output logic [WIDTH-1:0] ctr_cnt_in,
  input  logic [WIDTH-1:0] ctr_cnt_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wraps
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             per_q;
  logic             done_q;
  logic [7:0]       wraps_q;
  logic [7:0]       wraps_d;
  logic             terminal;

  assign terminal = (ctr_cnt_out == end_q);
  assign wraps_d  = (wraps_q == 8'hFF) ? 8'hFF : wraps_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      start_q <= '0;
      end_q   <= '0;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_CLEAR: state_q <= S_IDLE;
        S_IDLE: begin
          if (start) begin
            start_q <= start_val;
            end_q   <= end_val;
            per_q   <= periodic;
            wraps_q <= 8'h00;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: state_q <= stop ? S_CLEAR : S_RUN;
        S_RUN: begin
          // The counter is enabled this cycle when not terminal, so the pause edge still increments.
          if (stop) begin
            state_q <= S_CLEAR;
          end else if (terminal) begin
            done_q  <= 1'b1;
            wraps_q <= wraps_d;
            state_q <= per_q ? S_LOAD : S_IDLE;
          end else if (pause) begin
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (stop) begin
            state_q <= S_CLEAR;
          end else if (!pause) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign ctr_rst    = (state_q == S_CLEAR);
  assign ctr_load   = (state_q == S_LOAD);
  assign ctr_enab   = (state_q == S_RUN) && !terminal;
  assign ctr_cnt_in = (state_q == S_LOAD) ? start_q : '0;
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_HOLD);
  assign done       = done_q;
  assign wraps      = wraps_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: behavioural counter attached, runs predicted from start/end/pause arithmetic.
module tb_counter_sched;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, pause, periodic;
  logic [W-1:0] start_val, end_val;
  logic         ctr_rst, ctr_load, ctr_enab;
  logic [W-1:0] ctr_cnt_in;
  logic [W-1:0] cnt_q;
  logic         busy, done;
  logic [7:0]   wraps;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Attached counter: synchronous clear > load > enable.
  always_ff @(posedge clk) begin
    if (ctr_rst)       cnt_q <= '0;
    else if (ctr_load) cnt_q <= ctr_cnt_in;
    else if (ctr_enab) cnt_q <= cnt_q + 5'd1;
  end

  counter_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .start_val(start_val), .end_val(end_val),
    .ctr_rst(ctr_rst), .ctr_load(ctr_load), .ctr_enab(ctr_enab),
    .ctr_cnt_in(ctr_cnt_in), .ctr_cnt_out(cnt_q),
    .busy(busy), .done(done), .wraps(wraps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // One run from start acceptance; cycle c means the cycle after the c-th edge counted from the start edge.
  task automatic run(input logic [W-1:0] s, input logic [W-1:0] e, input bit per,
                     input int p, input int len, input int nper, input bit ign);
    logic [W-1:0] dd;
    logic [W-1:0] ecnt;
    int d, done1, last, nd, k, holds;
    bit edone, ebusy, eload;
    dd    = e - s;
    d     = int'(dd);
    done1 = 3 + d + len;
    last  = per ? done1 + (nper - 1) * (d + 2) : done1 + 1;
    nd    = 0;
    start = 1'b1; start_val = s; end_val = e; periodic = per;
    tick();
    start_val = W'($urandom); end_val = W'($urandom); periodic = 1'($urandom);
    for (int c = 1; c <= last; c++) begin
      pause = (len > 0) && (c >= 2 + p) && (c < 2 + p + len);
      start = ign && (c == 2);
      if (per) begin
        edone = (c >= done1) && (((c - done1) % (d + 2)) == 0);
        ebusy = 1'b1;
        eload = ((c - 1) % (d + 2)) == 0;
      end else begin
        edone = (c == done1);
        ebusy = (c < done1);
        eload = (c == 1);
      end
      if (edone) nd++;
      chk("done", 32'(done), 32'(edone));
      chk("wraps", 32'(wraps), 32'(sat(nd)));
      chk("busy", 32'(busy), 32'(ebusy));
      chk("ctr_load", 32'(ctr_load), 32'(eload));
      if (eload) chk("ctr_cnt_in", 32'(ctr_cnt_in), 32'(s));
      if (c >= 2) begin
        if (per) begin
          k = (c - 1) % (d + 2);
          ecnt = (k == 0) ? e : W'(int'(s) + k - 1);
        end else begin
          holds = 0;
          if (len > 0) begin
            holds = ((c - 1 < 2 + p + len) ? c - 1 : 2 + p + len) - (3 + p) + 1;
            if (holds < 0) holds = 0;
          end
          k = (c - 2) - holds;
          if (k > d) k = d;
          ecnt = W'(int'(s) + k);
        end
        chk("cnt", 32'(cnt_q), 32'(ecnt));
      end
      if (per && c == last) stop = 1'b1;
      tick();
    end
    pause = 1'b0;
    start = 1'b0;
    if (per) begin
      stop = 1'b0;
      chk("stop_ctr_rst", 32'(ctr_rst), 32'd1);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
      chk("stop_wraps", 32'(wraps), 32'(sat(nper)));
      tick();
      chk("stop_cnt", 32'(cnt_q), 32'd0);
      chk("stop_idle_rst", 32'(ctr_rst), 32'd0);
      chk("stop_wraps2", 32'(wraps), 32'(sat(nper)));
    end
  endtask

  initial begin
    logic [W-1:0] rs, rd;
    bit rper;
    int rp, rl;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
    start_val = '0; end_val = '0;
    tick(); tick(); tick();
    chk("rst_ctr_rst", 32'(ctr_rst), 32'd1);
    chk("rst_load", 32'(ctr_load), 32'd0);
    chk("rst_enab", 32'(ctr_enab), 32'd0);
    chk("rst_cnt_in", 32'(ctr_cnt_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wraps", 32'(wraps), 32'd0);
    rst = 1'b1;
    #1;
    chk("clear_ctr_rst", 32'(ctr_rst), 32'd1);
    tick();
    chk("idle_ctr_rst", 32'(ctr_rst), 32'd0);
    chk("idle_cnt", 32'(cnt_q), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    run(5'h03, 5'h06, 1'b0, 0, 0, 1, 1'b0);
    run(5'h1E, 5'h01, 1'b0, 0, 0, 1, 1'b0);
    run(5'h03, 5'h06, 1'b1, 0, 0, 3, 1'b0);
    run(5'h03, 5'h06, 1'b0, 1, 4, 1, 1'b0);
    run(5'h0A, 5'h0A, 1'b0, 0, 0, 1, 1'b0);
    run(5'h02, 5'h07, 1'b0, 0, 0, 1, 1'b1);
    run(5'h0A, 5'h0A, 1'b1, 0, 0, 257, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs   = W'($urandom);
      rd   = ($urandom_range(0, 7) == 0) ? 5'h1F : W'($urandom_range(0, 9));
      rper = 1'($urandom_range(0, 1));
      rp = 0; rl = 0;
      if (!rper && rd != 0 && $urandom_range(0, 1) == 1) begin
        rp = $urandom_range(0, int'(rd) - 1);
        rl = $urandom_range(1, 5);
      end
      run(rs, rs + rd, rper, rp, rl, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a periodic run, after one period has completed.
    start = 1'b1; start_val = 5'h00; end_val = 5'h02; periodic = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    chk("pre_arst_wraps", 32'(wraps), 32'd1);
    chk("pre_arst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ctr_rst", 32'(ctr_rst), 32'd1);
    chk("arst_enab", 32'(ctr_enab), 32'd0);
    chk("arst_load", 32'(ctr_load), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_wraps", 32'(wraps), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_arst_cnt", 32'(cnt_q), 32'd0);
    chk("post_arst_rst", 32'(ctr_rst), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
